mem_chipset_arb: RTL and testbench

Parametrised memory chipset for the processor top level. It replaces the fixed three-way address decode and result mux with an N-region decoder, a registered read-return pipeline and a second requester port (host/debug, e.g. the Arduino link) that shares the data memories with the CPU. A starvation counter guarantees host progress. The block sits between the CPU's memory port and the ROM/RAM instances.

---
 rtl/chipset_pkg.sv | 24 ++
 rtl/chipset_rd_pipe.sv | 27 ++
 rtl/mem_chipset_arb.sv | 123 ++++++++++++
 tb/tb_mem_chipset_arb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/chipset_pkg.sv
// Shared types for the memory chipset: region indices, requester owner and
// the read-return tag carried down the latency pipeline.
package chipset_pkg;

  localparam int REG_ROM = 0;
  localparam int REG_RAM = 1;
  localparam int REG_ARD = 2;

  // Region field is sized for the largest supported region count (up to 256).
  localparam int TAG_SEL_W = 8;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic                 valid;
    owner_e               owner;
    logic [TAG_SEL_W-1:0] region;
    logic                 unmapped;
  } rd_tag_t;

endpackage

// File: rtl/chipset_rd_pipe.sv
// RD_LAT-deep shift register of read tags; a synchronous clear drops every
// read still in flight.
module chipset_rd_pipe
  import chipset_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_chipset_arb.sv
// CPU/host memory chipset: priority arbiter with host starvation guard,
// N-region decode and a latency-matched read-return mux.
module mem_chipset_arb
  import chipset_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int NREG     = 3,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8,
  localparam int SEL_W   = $clog2(NREG),
  localparam int OFF_W   = ADDR_W - SEL_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_stall,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_err,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_gnt,
  output logic                        host_rvalid,
  output logic [DATA_W-1:0]           host_rdata,
  output logic [NREG-1:0]             mem_sel,
  output logic [OFF_W-1:0]            mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [NREG-1:0][DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  wait_cnt;
  logic              host_win, cpu_win, acc, acc_we, unmapped, rom_wr, hit;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [SEL_W-1:0]  region;
  owner_e            acc_owner;
  rd_tag_t           tag_in, tag_out;
  logic [DATA_W-1:0] ret_data, cpu_rdata_q, host_rdata_q;
  logic              cpu_err_q, cpu_rv, host_rv;

  always_comb begin
    // CPU has priority unless the host has been denied MAX_WAIT cycles in a row.
    host_win  = !rst && host_req && (!cpu_req || wait_cnt == CNT_W'(MAX_WAIT));
    cpu_win   = !rst && cpu_req && !host_win;
    acc       = host_win || cpu_win;
    acc_owner = host_win ? OWN_HOST : OWN_CPU;
    acc_we    = host_win ? host_we : cpu_we;
    acc_addr  = host_win ? host_addr : cpu_addr;
    acc_wdata = host_win ? host_wdata : cpu_wdata;

    region    = acc_addr[ADDR_W-1 -: SEL_W];
    unmapped  = int'(region) >= NREG;
    rom_wr    = acc_we && region == SEL_W'(REG_ROM);
    hit       = acc && !unmapped && !rom_wr;

    mem_sel = '0;
    if (hit) mem_sel[region] = 1'b1;
    mem_addr  = acc ? acc_addr[OFF_W-1:0] : '0;
    mem_we    = hit && acc_we;
    mem_wdata = acc ? acc_wdata : '0;

    cpu_stall = cpu_req && host_win;
    host_gnt  = host_win;

    tag_in.valid    = acc && !acc_we;
    tag_in.owner    = acc_owner;
    tag_in.region   = TAG_SEL_W'(region);
    tag_in.unmapped = unmapped;
  end

  always_ff @(posedge clk) begin
    if (rst || !host_req || host_win) wait_cnt <= '0;
    else if (wait_cnt != CNT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cpu_err_q <= 1'b0;
    else     cpu_err_q <= cpu_win && (unmapped || rom_wr);
  end

  chipset_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Unmapped reads fall through the region match and return zero.
  always_comb begin
    ret_data = '0;
    if (!tag_out.unmapped)
      for (int r = 0; r < NREG; r++)
        if (tag_out.region == TAG_SEL_W'(r)) ret_data = mem_rdata[r];
    cpu_rv  = !rst && tag_out.valid && tag_out.owner == OWN_CPU;
    host_rv = !rst && tag_out.valid && tag_out.owner == OWN_HOST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (cpu_rv)  cpu_rdata_q  <= ret_data;
      if (host_rv) host_rdata_q <= ret_data;
    end
  end

  assign cpu_rvalid  = cpu_rv;
  assign host_rvalid = host_rv;
  assign cpu_rdata   = rst ? '0 : (cpu_rv ? ret_data : cpu_rdata_q);
  assign host_rdata  = rst ? '0 : (host_rv ? ret_data : host_rdata_q);
  assign cpu_err     = cpu_err_q && !rst;

endmodule

// File: tb/tb_mem_chipset_arb.sv
// Directed bench: three chipset instances (RD_LAT 1, 2, 3) share stimulus;
// each scenario checks the instance whose latency it targets.
module tb_mem_chipset_arb;

  localparam int ADDR_W = 20, DATA_W = 32, NREG = 3, MAX_WAIT = 8, OFF_W = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cpu_req, cpu_we, host_req, host_we;
  logic [ADDR_W-1:0] cpu_addr, host_addr;
  logic [DATA_W-1:0] cpu_wdata, host_wdata;
  logic [NREG-1:0][DATA_W-1:0] mem_rdata;

  logic              cpu_stall [3], cpu_rvalid [3], cpu_err [3];
  logic              host_gnt [3], host_rvalid [3], mem_we [3];
  logic [DATA_W-1:0] cpu_rdata [3], host_rdata [3], mem_wdata [3];
  logic [NREG-1:0]   mem_sel [3];
  logic [OFF_W-1:0]  mem_addr [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_chipset_arb #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG), .RD_LAT(g + 1), .MAX_WAIT(MAX_WAIT)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall[g]), .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
      .cpu_err(cpu_err[g]),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt[g]), .host_rvalid(host_rvalid[g]), .host_rdata(host_rdata[g]),
      .mem_sel(mem_sel[g]), .mem_addr(mem_addr[g]), .mem_we(mem_we[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata)
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 0; cpu_we = 0; host_req = 0; host_we = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 20'h40001; host_req = 1; host_addr = 20'h80001;
    tick(); tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++; if (cpu_stall[g] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %b want 0", g, cpu_stall[g]); end
      checks++; if (host_gnt[g] !== 1'b0) begin errors++; $display("FAIL reset_gnt[%0d] got %b want 0", g, host_gnt[g]); end
      checks++; if (mem_sel[g] !== 3'b000) begin errors++; $display("FAIL reset_sel[%0d] got %b want 000", g, mem_sel[g]); end
      checks++; if (cpu_rvalid[g] !== 1'b0 || host_rvalid[g] !== 1'b0) begin errors++; $display("FAIL reset_rvalid[%0d] got %b/%b want 0/0", g, cpu_rvalid[g], host_rvalid[g]); end
      checks++; if (cpu_rdata[g] !== '0 || cpu_err[g] !== 1'b0 || mem_we[g] !== 1'b0) begin errors++; $display("FAIL reset_misc[%0d] rdata=%h err=%b we=%b want 0", g, cpu_rdata[g], cpu_err[g], mem_we[g]); end
    end
    tick();
    rst = 0; host_req = 0;
    @(negedge clk);
    checks++; if (mem_sel[0] !== 3'b010 || cpu_stall[0] !== 1'b0) begin errors++; $display("FAIL first_accept sel=%b stall=%b want 010/0", mem_sel[0], cpu_stall[0]); end
    tick();
    idle(4);
  endtask

  task automatic test_cpu_read();
    mem_rdata[1] = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h40005;
    @(negedge clk);
    checks++; if (mem_sel[0] !== 3'b010) begin errors++; $display("FAIL cpu_rd_sel got %b want 010", mem_sel[0]); end
    checks++; if (mem_addr[0] !== 18'h5) begin errors++; $display("FAIL cpu_rd_addr got %h want 5", mem_addr[0]); end
    checks++; if (mem_we[0] !== 1'b0 || cpu_stall[0] !== 1'b0) begin errors++; $display("FAIL cpu_rd_we_stall got %b/%b want 0/0", mem_we[0], cpu_stall[0]); end
    tick(); cpu_req = 0;
    @(negedge clk);
    checks++; if (cpu_rvalid[0] !== 1'b1 || cpu_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_ret got %b/%h want 1/deadbeef", cpu_rvalid[0], cpu_rdata[0]); end
    checks++; if (host_rvalid[0] !== 1'b0) begin errors++; $display("FAIL cpu_rd_host_rv got %b want 0", host_rvalid[0]); end
    tick(); mem_rdata[1] = 32'h0BAD0BAD;
    @(negedge clk);
    checks++; if (cpu_rvalid[0] !== 1'b0 || cpu_rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_hold got %b/%h want 0/deadbeef", cpu_rvalid[0], cpu_rdata[0]); end
    idle(4);
  endtask

  task automatic test_rom_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00010; cpu_wdata = 32'h55AA55AA;
    @(negedge clk);
    checks++; if (mem_we[0] !== 1'b0 || mem_sel[0] !== 3'b000) begin errors++; $display("FAIL rom_wr_strobe we=%b sel=%b want 0/000", mem_we[0], mem_sel[0]); end
    checks++; if (cpu_err[0] !== 1'b0 || cpu_stall[0] !== 1'b0) begin errors++; $display("FAIL rom_wr_t err=%b stall=%b want 0/0", cpu_err[0], cpu_stall[0]); end
    tick(); cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    checks++; if (cpu_err[0] !== 1'b1 || cpu_rvalid[0] !== 1'b0) begin errors++; $display("FAIL rom_wr_err err=%b rv=%b want 1/0", cpu_err[0], cpu_rvalid[0]); end
    tick();
    @(negedge clk);
    checks++; if (cpu_err[0] !== 1'b0) begin errors++; $display("FAIL rom_wr_pulse got %b want 0", cpu_err[0]); end
    idle(4);
  endtask

  task automatic test_ram_write_unmapped();
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h80123; cpu_wdata = 32'hA5A50001;
    @(negedge clk);
    checks++; if (mem_we[0] !== 1'b1 || mem_sel[0] !== 3'b100 || mem_wdata[0] !== 32'hA5A50001 || mem_addr[0] !== 18'h123) begin errors++; $display("FAIL ram_wr we=%b sel=%b wd=%h a=%h want 1/100/a5a50001/123", mem_we[0], mem_sel[0], mem_wdata[0], mem_addr[0]); end
    tick(); cpu_we = 0; cpu_addr = 20'hC0001;
    @(negedge clk);
    checks++; if (cpu_err[0] !== 1'b0 || cpu_rvalid[0] !== 1'b0) begin errors++; $display("FAIL ram_wr_noerr err=%b rv=%b want 0/0", cpu_err[0], cpu_rvalid[0]); end
    checks++; if (mem_sel[0] !== 3'b000 || mem_we[0] !== 1'b0) begin errors++; $display("FAIL unmap_sel sel=%b we=%b want 000/0", mem_sel[0], mem_we[0]); end
    tick(); cpu_req = 0;
    @(negedge clk);
    checks++; if (cpu_rvalid[0] !== 1'b1 || cpu_rdata[0] !== 32'h0 || cpu_err[0] !== 1'b1) begin errors++; $display("FAIL unmap_ret rv=%b rd=%h err=%b want 1/0/1", cpu_rvalid[0], cpu_rdata[0], cpu_err[0]); end
    idle(4);
  endtask

  task automatic test_starvation();
    mem_rdata[1] = 32'h11110000; mem_rdata[2] = 32'hCAFEF00D;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h40002;
    host_req = 1; host_we = 0; host_addr = 20'h80003;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++; if (host_gnt[0] !== (i == 9)) begin errors++; $display("FAIL starve_gnt cyc%0d got %b want %b", i, host_gnt[0], i == 9); end
      checks++; if (cpu_stall[0] !== (i == 9)) begin errors++; $display("FAIL starve_stall cyc%0d got %b want %b", i, cpu_stall[0], i == 9); end
      checks++; if (mem_sel[0] !== ((i == 9) ? 3'b100 : 3'b010)) begin errors++; $display("FAIL starve_sel cyc%0d got %b", i, mem_sel[0]); end
      if (i == 10) begin
        checks++; if (host_rvalid[0] !== 1'b1 || host_rdata[0] !== 32'hCAFEF00D || cpu_rvalid[0] !== 1'b0) begin errors++; $display("FAIL starve_ret hrv=%b hrd=%h crv=%b want 1/cafef00d/0", host_rvalid[0], host_rdata[0], cpu_rvalid[0]); end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_host_read_lat3();
    mem_rdata[2] = 32'h600DF00D;
    host_req = 1; host_we = 0; host_addr = 20'h80007;
    @(negedge clk);
    checks++; if (host_gnt[2] !== 1'b1 || mem_sel[2] !== 3'b100 || mem_addr[2] !== 18'h7) begin errors++; $display("FAIL host_rd_t gnt=%b sel=%b a=%h want 1/100/7", host_gnt[2], mem_sel[2], mem_addr[2]); end
    tick(); host_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (host_rvalid[2] !== (k == 3)) begin errors++; $display("FAIL host_rd_rv T+%0d got %b want %b", k, host_rvalid[2], k == 3); end
      checks++; if (cpu_rvalid[2] !== 1'b0) begin errors++; $display("FAIL host_rd_cpu_rv T+%0d got %b want 0", k, cpu_rvalid[2]); end
      if (k == 3) begin
        checks++; if (host_rdata[2] !== 32'h600DF00D) begin errors++; $display("FAIL host_rd_data got %h want 600df00d", host_rdata[2]); end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      mem_rdata[1] = 32'h10000000 + k;
      mem_rdata[2] = 32'h20000000 + k;
      cpu_req = (k < 6) && (k % 2 == 0); cpu_we = 0; cpu_addr = 20'h40000 + k;
      host_req = (k < 6) && (k % 2 == 1); host_we = 0; host_addr = 20'h80000 + k;
      @(negedge clk);
      if (k < 6) begin
        checks++; if (cpu_stall[1] !== 1'b0 || host_gnt[1] !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_accept cyc%0d stall=%b gnt=%b", k, cpu_stall[1], host_gnt[1]); end
      end
      if (k >= 2) begin
        checks++; if (cpu_rvalid[1] !== (k % 2 == 0) || host_rvalid[1] !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_owner cyc%0d crv=%b hrv=%b", k, cpu_rvalid[1], host_rvalid[1]); end
        if (k % 2 == 0) begin
          checks++; if (cpu_rdata[1] !== 32'h10000000 + k) begin errors++; $display("FAIL b2b_cdata cyc%0d got %h want %h", k, cpu_rdata[1], 32'h10000000 + k); end
        end else begin
          checks++; if (host_rdata[1] !== 32'h20000000 + k) begin errors++; $display("FAIL b2b_hdata cyc%0d got %h want %h", k, host_rdata[1], 32'h20000000 + k); end
        end
      end
      tick();
    end
    idle(4);
  endtask

  task automatic test_reset_inflight();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h40009;
    tick();
    rst = 1; cpu_req = 0; host_req = 1; host_addr = 20'h80001;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++; if (cpu_rvalid[g] !== 1'b0 || host_gnt[g] !== 1'b0 || mem_sel[g] !== 3'b000 || cpu_rdata[g] !== '0 || host_rdata[g] !== '0) begin errors++; $display("FAIL rst_mid[%0d] rv=%b gnt=%b sel=%b rd=%h hrd=%h want all 0", g, cpu_rvalid[g], host_gnt[g], mem_sel[g], cpu_rdata[g], host_rdata[g]); end
    end
    tick();
    rst = 0; host_req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++; if (cpu_rvalid[g] !== 1'b0 || host_rvalid[g] !== 1'b0) begin errors++; $display("FAIL rst_drop[%0d] cyc%0d crv=%b hrv=%b want 0/0", g, k, cpu_rvalid[g], host_rvalid[g]); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    mem_rdata[0] = 32'h12345678; mem_rdata[1] = 32'h0; mem_rdata[2] = 32'h0;
    #1;
    test_reset();
    test_cpu_read();
    test_rom_write();
    test_ram_write_unmapped();
    test_starvation();
    test_host_read_lat3();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
